// File: rtl/io_write_arbiter.sv
// io_write_arbiter: two-port write arbiter; CPU (port 0) has priority and may lock the bus, DMA (port 1) wins after STARVE_LIMIT losses
//   clk, reset_n                       : clock, asynchronous active-low reset
//   p0_valid/addr/data/en/lock, p0_ready : CPU write request, lock keeps ownership after the transfer
//   p1_valid/addr/data/en, p1_ready      : DMA write request
//   dwrite_addr/data/en                : registered write bus, en is 00 in cycles after no transfer
//   last_grant, locked                 : port of the latest transfer, CPU holds the bus
module io_write_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        p0_valid,
   output logic        p0_ready,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p0_data,
   input  logic [1:0]  p0_en,
   input  logic        p0_lock,
   input  logic        p1_valid,
   output logic        p1_ready,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p1_data,
   input  logic [1:0]  p1_en,
   output logic [15:0] dwrite_addr,
   output logic [15:0] dwrite_data,
   output logic [1:0]  dwrite_en,
   output logic        last_grant,
   output logic        locked
);
   typedef enum logic {OPEN, LOCKED} state_t;
   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
   state_t     state, state_nxt;
   logic [3:0] starve_cnt, starve_nxt;
   // port 1 wins when unopposed or starving, never while locked; port 0 takes every other request
   always_comb begin
      p1_ready   = reset_n && p1_valid && state == OPEN && (!p0_valid || starve_cnt == LIM);
      p0_ready   = reset_n && p0_valid && !p1_ready;
      starve_nxt = (p1_valid && !p1_ready) ? ((starve_cnt == LIM) ? LIM : starve_cnt + 4'd1) : 4'd0;
      state_nxt  = p0_ready ? (p0_lock ? LOCKED : OPEN) : state;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= OPEN;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dwrite_addr <= 16'd0;
         dwrite_data <= 16'd0;
         dwrite_en   <= 2'b00;
         last_grant  <= 1'b0;
      end else begin
         dwrite_en <= p1_ready ? p1_en : (p0_ready ? p0_en : 2'b00);
         if (p0_ready || p1_ready) begin
            dwrite_addr <= p1_ready ? p1_addr : p0_addr;
            dwrite_data <= p1_ready ? p1_data : p0_data;
            last_grant  <= p1_ready;
         end
      end
   end
   assign locked = state == LOCKED;
endmodule

// File: tb/tb_io_write_arbiter.sv
// tb_io_write_arbiter: directed and random stimulus against a rule-level model of io_write_arbiter
module tb_io_write_arbiter;
   localparam int LIMIT = 4;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        p0_valid = 1'b0, p0_lock = 1'b0, p1_valid = 1'b0;
   logic [15:0] p0_addr = '0, p0_data = '0, p1_addr = '0, p1_data = '0;
   logic [1:0]  p0_en = '0, p1_en = '0;
   logic        p0_ready, p1_ready, last_grant, locked;
   logic [15:0] dwrite_addr, dwrite_data;
   logic [1:0]  dwrite_en;
   int tests = 0, fails = 0;
   bit          m_locked, m_last;
   int          m_starve;
   logic [15:0] m_addr, m_data;
   logic [1:0]  m_en;

   io_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
      .p0_en(p0_en), .p0_lock(p0_lock),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data), .p1_en(p1_en),
      .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
      .last_grant(last_grant), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_last = 0; m_starve = 0; m_addr = '0; m_data = '0; m_en = '0;
   endtask

   // one arbitration cycle; entered just after a rising edge
   task automatic step(input bit v0, input logic [15:0] a0, input logic [15:0] d0, input logic [1:0] e0,
                       input bit l0, input bit v1, input logic [15:0] a1, input logic [15:0] d1,
                       input logic [1:0] e1);
      bit g0, g1;
      p0_valid = v0; p0_addr = a0; p0_data = d0; p0_en = e0; p0_lock = l0;
      p1_valid = v1; p1_addr = a1; p1_data = d1; p1_en = e1;
      g1 = v1 && !m_locked && (!v0 || m_starve == LIMIT);
      g0 = v0 && !g1;
      @(negedge clk);
      chk("p0_ready", p0_ready, g0);
      chk("p1_ready", p1_ready, g1);
      if (g0) begin m_addr = a0; m_data = d0; m_en = e0; m_last = 0; m_locked = l0; end
      else if (g1) begin m_addr = a1; m_data = d1; m_en = e1; m_last = 1; end
      else m_en = 2'b00;
      m_starve = (v1 && !g1) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      @(posedge clk);
      #1;
      chk("dwrite_addr", dwrite_addr, m_addr);
      chk("dwrite_data", dwrite_data, m_data);
      chk("dwrite_en", dwrite_en, m_en);
      chk("last_grant", last_grant, m_last);
      chk("locked", locked, m_locked);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #2;
      chk("rst_p0_ready", p0_ready, 0);
      chk("rst_locked", locked, 0);
      chk("rst_dwrite_en", dwrite_en, 0);
      chk("rst_dwrite_addr", dwrite_addr, 0);
      chk("rst_last_grant", last_grant, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      // single port 0 write, then a hold cycle
      step(1, 16'h0028, 16'h00FF, 2'b01, 0, 0, 0, 0, 0);
      idle();
      chk("hold_addr", dwrite_addr, 16'h0028);
      chk("hold_data", dwrite_data, 16'h00FF);
      chk("hold_en", dwrite_en, 2'b00);
      // starvation: both valid for ten cycles
      for (int i = 0; i < 10; i++) step(1, 16'h1000 + 16'(i), 16'(i), 2'b11, 0, 1, 16'h2000 + 16'(i), 16'(i), 2'b10);
      chk("starve_p1_win", last_grant, 1);
      // lock held through idle cycles with p1 pending
      step(1, 16'h0100, 16'h1111, 2'b11, 1, 1, 16'h0200, 16'h2222, 2'b11);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 16'h0200, 16'h2222, 2'b11);
      step(1, 16'h0104, 16'h3333, 2'b11, 0, 1, 16'h0200, 16'h2222, 2'b11);
      step(0, 0, 0, 0, 0, 1, 16'h0200, 16'h2222, 2'b11);
      chk("unlock_p1_addr", dwrite_addr, 16'h0200);
      // lock with starvation: p1 wins first open cycle despite p0
      step(1, 16'h0300, 16'h4444, 2'b01, 1, 1, 16'h0400, 16'h5555, 2'b01);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 16'h0400, 16'h5555, 2'b01);
      step(1, 16'h0304, 16'h6666, 2'b01, 0, 1, 16'h0400, 16'h5555, 2'b01);
      step(1, 16'h0308, 16'h7777, 2'b01, 0, 1, 16'h0400, 16'h5555, 2'b01);
      chk("lockstarve_last", last_grant, 1);
      // null write on port 1
      step(0, 0, 0, 0, 0, 1, 16'h0030, 16'hABCD, 2'b00);
      chk("null_addr", dwrite_addr, 16'h0030);
      chk("null_en", dwrite_en, 2'b00);
      chk("null_last", last_grant, 1);
      // reset mid-lock, asynchronously
      step(1, 16'h0500, 16'h8888, 2'b11, 1, 1, 16'h0600, 16'h9999, 2'b11);
      p0_valid = 0; p1_valid = 1;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_dwrite_en", dwrite_en, 0);
      chk("arst_p0_ready", p0_ready, 0);
      chk("arst_p1_ready", p1_ready, 0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      step(0, 0, 0, 0, 0, 1, 16'h0700, 16'hAAAA, 2'b11);
      chk("post_rst_last", last_grant, 1);
      // random traffic
      for (int i = 0; i < 400; i++)
         step(bit'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 2'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 2'($urandom));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/io_write_arbiter.md
IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive lost arbitrations before port 1 is forced to win (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port p0_valid, input, 1, port 0 (CPU) write request.
REQ-005 SHALL have port p0_ready, output, 1, port 0 accepted this cycle (combinational).
REQ-006 SHALL have ports p0_addr (input, 16, byte address), p0_data (input, 16, write data) and p0_en (input, 2, byte-lane enables).
REQ-007 SHALL have port p0_lock, input, 1, requests that port 0 keep exclusive bus ownership after this transfer.
REQ-008 SHALL have ports p1_valid (input, 1), p1_ready (output, 1), p1_addr (input, 16), p1_data (input, 16) and p1_en (input, 2); these are the port 1 (DMA) equivalents, with no lock input.
REQ-009 SHALL have ports dwrite_addr (output, 16), dwrite_data (output, 16) and dwrite_en (output, 2), a registered write bus to the IO system.
REQ-010 SHALL have port last_grant, output, 1, the port index of the most recent accepted transfer.
REQ-011 SHALL have port locked, output, 1, high while in state LOCKED.

Function
REQ-012 SHALL transfer a port's request in a cycle when valid and ready are both high; at most one port SHALL be ready per cycle.
REQ-013 SHALL assert ready combinationally from the current valid inputs, state and starve counter; ready SHALL never be high when the port's valid is low.
REQ-014 SHALL, in state OPEN with only one port valid, grant that port.
REQ-015 SHALL, in state OPEN with both ports valid, grant port 0 unless starve_cnt == STARVE_LIMIT, in which case port 1 is granted.
REQ-016 SHALL, in state LOCKED, grant only port 0; p1_ready SHALL be 0 regardless of starve_cnt.
REQ-017 SHALL update the 4-bit starve_cnt as follows:
- +1 when p1_valid=1 and port 1 is not granted, saturating at STARVE_LIMIT;
- set to 0 when port 1 is granted or p1_valid=0.
REQ-018 SHALL transition OPEN->LOCKED on a port 0 transfer with p0_lock=1.
REQ-019 SHALL transition LOCKED->OPEN on a port 0 transfer with p0_lock=0; LOCKED SHALL otherwise persist, including through idle cycles.
REQ-020 SHALL, on a transfer, register that port's addr/data/en onto dwrite_addr/dwrite_data/dwrite_en for exactly the next cycle (latency 1).
REQ-021 SHALL, in a cycle after no transfer, drive dwrite_en=2'b00 and hold dwrite_addr/dwrite_data at their previous values.
REQ-022 SHALL forward a transfer with en=2'b00 unchanged; it still counts as a grant for REQ-017 and REQ-018/019.
REQ-023 SHALL update last_grant only on a transfer.

Reset
REQ-024 SHALL, while reset_n=0, immediately force: state OPEN, starve_cnt 0, dwrite_addr 0, dwrite_data 0, dwrite_en 2'b00, last_grant 0, locked 0.
REQ-025 SHALL force p0_ready=0 and p1_ready=0 while reset_n=0.
REQ-026 SHALL abandon a LOCKED sequence on reset with no write issued; the first rising edge after reset_n rises SHALL arbitrate normally.

Verification
REQ-027 Single port 0: p0 valid with addr 16'h0028, data 16'h00FF, en 01 for one cycle -> p0_ready=1 that cycle; next cycle dwrite_addr=0028, dwrite_data=00FF, dwrite_en=01, last_grant=0; following cycle dwrite_en=00 with addr/data held.
REQ-028 Starvation: both ports valid continuously, STARVE_LIMIT=4 -> p0 granted cycles 0-3, p1 granted cycle 4 and starve_cnt reset to 0, p0 granted cycles 5-8, p1 granted cycle 9.
REQ-029 Lock: p0 transfer with lock=1, then 3 idle cycles, then p0 transfer with lock=0, with p1_valid=1 throughout -> p1_ready=0 until the cycle after the lock=0 transfer, then p1 is granted; locked=1 exactly between the two p0 transfers.
REQ-030 Lock with starvation: starve_cnt reaches 4 while LOCKED -> p1 not granted; p1 is granted on the first OPEN cycle even if p0_valid=1.
REQ-031 Reset mid-lock: assert reset_n=0 asynchronously while LOCKED with p1 pending -> locked, dwrite_en and both ready signals drop to 0 without waiting for a clock edge; after release, p1 alone valid is granted on the first edge.
REQ-032 Null write: p1 valid with en=00, addr 16'h0030 -> transfer accepted, dwrite_en=00, dwrite_addr=0030, last_grant=1.
